instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage directly downstream of the PC register in the multi-cycle MIPS core.
//   On a fetch_start pulse from the control unit, it latches the PC's currentAddress.
//   It then reads the word from instruction memory over a req/ack handshake and
//   holds it in the IR. The IR is presented to decode with a valid/ready handshake.
//   Also produces PC+4 for the next-PC mux feeding the PC's newAddress.
// PARAMETERS
//   ADDR_W    32  address width (PC / imem address)
//   DATA_W    32  instruction width
//   MAX_WAIT  15  max cycles in REQ without imem_ack before timeout (>=1)
// PORTS
//   clk              in   1       clock, all state updates on rising edge
//   rst              in   1       asynchronous reset, active-high
//   fetch_start      in   1       1-cycle request from control unit to fetch at current_address
//   current_address  in   ADDR_W  PC register output
//   imem_req         out  1       instruction memory read request
//   imem_addr        out  ADDR_W  latched fetch address, stable while imem_req=1
//   imem_ack         in   1       memory returns imem_rdata this cycle
//   imem_rdata       in   DATA_W  instruction word
//   ir               out  DATA_W  instruction register
//   ir_valid         out  1       ir holds an unconsumed instruction
//   ir_ready         in   1       decode accepts ir this cycle
//   pc_plus4         out  ADDR_W  latched fetch address + 4
//   busy             out  1       1 in any state other than IDLE
//   fetch_err        out  1       1-cycle pulse on timeout (or misalign, see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, any state):
//     - state=IDLE, wait counter=0.
//     - All outputs 0, including ir, pc_plus4 and imem_addr.
//     - An imem_ack arriving after reset is ignored.
//   FSM states: IDLE, REQ, VALID.
//   IDLE:
//     - fetch_start=1 -> latch addr=current_address, pc_plus4=addr+4, go to REQ.
//   REQ:
//     - imem_req=1; imem_addr constant.
//     - imem_ack=1 -> ir<=imem_rdata, ir_valid<=1, go to VALID.
//     - Otherwise the wait counter increments.
//     - Counter reaches MAX_WAIT with no ack -> fetch_err pulses, go to IDLE; ir and ir_valid unchanged (0).
//     - Ack in the same cycle as the timeout: ack wins, no error.
//   VALID:
//     - ir and ir_valid held until ir_valid & ir_ready.
//     - Handshake -> IDLE, ir_valid<=0.
//     - Handshake with fetch_start=1 in the same cycle -> go directly to REQ with the new address (back-to-back).
//   fetch_start outside IDLE, or not coincident with a VALID handshake: ignored, no effect.
//   Latency:
//     - fetch_start at edge N -> imem_req=1 after N.
//     - Ack in that cycle -> ir_valid=1 after edge N+1 (min 2 cycles).
//   Arithmetic:
//     - pc_plus4 is modulo 2^ADDR_W; 0xFFFFFFFC -> 0x00000000.
//     - ir retains its last value after consumption.
//   Wait counter: clears on entry to REQ; width = clog2(MAX_WAIT+1).
// CONFIGURATION
//   IF_ALIGN_CHECK_EN defined:
//     - fetch_start with current_address[1:0]!=0 -> no request issued.
//     - fetch_err pulses the following cycle; state stays IDLE.
//   IF_ALIGN_CHECK_EN undefined:
//     - Address accepted; imem_addr[1:0] forced to 2'b00.
//     - pc_plus4 computed from the forced address.
// TESTING
//   1. addr=0x00400000, start, ack the first REQ cycle with 0x8C080004
//      -> ir=0x8C080004 and ir_valid 2 cycles after start; pc_plus4=0x00400004.
//   2. Ack after 3 REQ cycles
//      -> imem_req high exactly 3 cycles (ack in the 3rd); imem_addr stable; fetch_err stays 0.
//   3. MAX_WAIT=15, no ack
//      -> fetch_err 1-cycle pulse after 15 REQ cycles; busy=0 next; ir_valid=0.
//   4. ir_ready low 5 cycles in VALID, then high together with fetch_start at 0x10
//      -> ir stable; next REQ with imem_addr=0x10, no IDLE cycle.
//   5. addr=0xFFFFFFFC -> pc_plus4=0x00000000.
//      Assert rst mid-REQ -> all outputs 0 immediately; late ack has no effect.
//   6. With IF_ALIGN_CHECK_EN, addr=0x00400002 -> fetch_err pulse, imem_req never 1.
//      Without the macro -> imem_addr=0x00400000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC latch, imem req/ack, IR with valid/ready (option macro IF_ALIGN_CHECK_EN)
module instr_fetch_unit #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_start,
   input  logic [ADDR_W-1:0] current_address,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   input  logic              ir_ready,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              busy,
   output logic              fetch_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [ADDR_W-1:0]  pc4_q, pc4_d;
   logic [DATA_W-1:0]  ir_q;
   logic               ir_valid_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q, err_d;

   logic               handshake;
   logic               take;
   logic               launch;
   logic               align_err;
   logic               timeout;
   logic [ADDR_W-1:0]  fetch_addr;

   // decode consumes the IR; ir_valid_q is only ever set while in VALID
   assign handshake = ir_valid_q & ir_ready;

   // a start only counts in IDLE or together with the VALID handshake
   assign take = fetch_start & ((state_q == S_IDLE) | ((state_q == S_VALID) & handshake));

`ifdef IF_ALIGN_CHECK_EN
   // misaligned starts are refused and reported instead of being fetched
   assign launch     = take & (current_address[1:0] == 2'b00);
   assign align_err  = take & (current_address[1:0] != 2'b00);
   assign fetch_addr = current_address;
`else
   // low address bits are dropped so the fetch is always word aligned
   assign launch     = take;
   assign align_err  = 1'b0;
   assign fetch_addr = current_address & ~ADDR_W'(3);
`endif

   // timeout on the last allowed REQ cycle; a coincident ack takes priority
   assign timeout = (state_q == S_REQ) & ~imem_ack & (cnt_q == CNT_W'(MAX_WAIT - 1));

   assign addr_d = fetch_addr;
   assign pc4_d  = fetch_addr + ADDR_W'(4);
   assign err_d  = timeout | align_err;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (launch) state_d = S_REQ;
         end
         S_REQ: begin
            if (imem_ack)     state_d = S_VALID;
            else if (timeout) state_d = S_IDLE;
         end
         S_VALID: begin
            if (handshake) state_d = launch ? S_REQ : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      imem_req = 1'b0;
      busy     = 1'b0;
      case (state_q)
         S_REQ:   begin imem_req = 1'b1; busy = 1'b1; end
         S_VALID: busy = 1'b1;
         default: ;
      endcase
   end

   // fetch address, PC+4, wait counter, IR and error pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= '0;
         pc4_q      <= '0;
         cnt_q      <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         err_q <= err_d;
         if (launch) begin
            addr_q <= addr_d;
            pc4_q  <= pc4_d;
            cnt_q  <= '0;
         end else if ((state_q == S_REQ) && !imem_ack) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if ((state_q == S_REQ) && imem_ack) begin
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
         end else if (handshake) begin
            ir_valid_q <= 1'b0;
         end
      end
   end

   assign imem_addr = addr_q;
   assign pc_plus4  = pc4_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic [31:0] current_address;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] pc_plus4;
   logic        busy;
   logic        fetch_err;

   typedef struct {
      bit          is_err;
      logic [31:0] ir;
      logic [31:0] pc4;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_start     (fetch_start),
      .current_address (current_address),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .ir              (ir),
      .ir_valid        (ir_valid),
      .ir_ready        (ir_ready),
      .pc_plus4        (pc_plus4),
      .busy            (busy),
      .fetch_err       (fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: pops one expectation per error pulse or IR handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst && fetch_err) begin
         if (exp_q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("sb_err_kind", 32'(fetch_err), 32'(e.is_err));
         end
      end
      if (!rst && ir_valid && ir_ready) begin
         if (exp_q.size() == 0) check("unexpected_ir", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("sb_kind", 32'(e.is_err), 32'd0);
            check("sb_ir", ir, e.ir);
            check("sb_pc4", pc_plus4, e.pc4);
         end
      end
   end

   task automatic start(input logic [31:0] addr);
      fetch_start     = 1'b1;
      current_address = addr;
      tick();
      fetch_start     = 1'b0;
   endtask

   // already in REQ: hold for 'waits' cycles, acking in the last one
   task automatic serve(input logic [31:0] exp_addr, input int waits,
                        input logic [31:0] data, input logic [31:0] exp_pc4);
      exp_t e;
      e.is_err = 1'b0; e.ir = data; e.pc4 = exp_pc4;
      exp_q.push_back(e);
      for (int i = 1; i <= waits; i++) begin
         check("req_high", 32'(imem_req), 32'd1);
         check("addr_stable", imem_addr, exp_addr);
         check("no_err", 32'(fetch_err), 32'd0);
         if (i == waits) begin
            imem_ack   = 1'b1;
            imem_rdata = data;
         end
         tick();
      end
      imem_ack = 1'b0;
      check("req_dropped", 32'(imem_req), 32'd0);
      check("ir_valid_set", 32'(ir_valid), 32'd1);
      check("ir_value", ir, data);
      check("no_err_after", 32'(fetch_err), 32'd0);
   endtask

   initial begin
      exp_t e;
      int   n;
      rst = 1'b1; fetch_start = 1'b0; current_address = '0;
      imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_ir", ir, 32'h0);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      check("rst_pc4", pc_plus4, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(fetch_err), 32'd0);

      // 1: ack in first REQ cycle, IR valid two cycles after start
      start(32'h0040_0000);
      check("t1_pc4", pc_plus4, 32'h0040_0004);
      serve(32'h0040_0000, 1, 32'h8C08_0004, 32'h0040_0004);
      tick();
      check("t1_consumed", 32'(ir_valid), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);

      // 2: ack after three REQ cycles
      start(32'h0040_0004);
      serve(32'h0040_0004, 3, 32'h2008_0005, 32'h0040_0008);
      tick();

      // 3: no ack, timeout after 15 REQ cycles
      e.is_err = 1'b1; e.ir = '0; e.pc4 = '0;
      exp_q.push_back(e);
      start(32'h0040_0100);
      n = 0;
      while (imem_req && n < 40) begin
         n++;
         tick();
      end
      check("t3_req_cycles", 32'(n), 32'd15);
      check("t3_err_pulse", 32'(fetch_err), 32'd1);
      check("t3_busy", 32'(busy), 32'd0);
      check("t3_ir_valid", 32'(ir_valid), 32'd0);
      tick();
      check("t3_err_cleared", 32'(fetch_err), 32'd0);

      // 4: decode stalls 5 cycles, then back-to-back fetch at 0x10
      ir_ready = 1'b0;
      start(32'h0000_0020);
      serve(32'h0000_0020, 1, 32'hAAAA_5555, 32'h0000_0024);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_ir_hold", ir, 32'hAAAA_5555);
         check("t4_valid_hold", 32'(ir_valid), 32'd1);
      end
      ir_ready = 1'b1;
      start(32'h0000_0010);
      check("t4_b2b_busy", 32'(busy), 32'd1);
      check("t4_b2b_addr", imem_addr, 32'h0000_0010);
      serve(32'h0000_0010, 2, 32'h1234_5678, 32'h0000_0014);
      tick();

      // 5: PC+4 wraps, then reset in the middle of REQ
      start(32'hFFFF_FFFC);
      check("t5_wrap", pc_plus4, 32'h0000_0000);
      serve(32'hFFFF_FFFC, 1, 32'h0000_0008, 32'h0000_0000);
      tick();
      start(32'h0040_0008);
      tick();
      rst = 1'b1;
      #1;
      check("t5_rst_req", 32'(imem_req), 32'd0);
      check("t5_rst_addr", imem_addr, 32'h0);
      check("t5_rst_pc4", pc_plus4, 32'h0);
      check("t5_rst_ir", ir, 32'h0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      rst = 1'b0;
      tick();
      imem_ack = 1'b0;
      check("t5_late_ack_valid", 32'(ir_valid), 32'd0);
      check("t5_late_ack_ir", ir, 32'h0);
      check("t5_late_ack_busy", 32'(busy), 32'd0);

      // 6: misaligned start
`ifdef IF_ALIGN_CHECK_EN
      e.is_err = 1'b1; e.ir = '0; e.pc4 = '0;
      exp_q.push_back(e);
      start(32'h0040_0002);
      check("t6_no_req", 32'(imem_req), 32'd0);
      check("t6_err", 32'(fetch_err), 32'd1);
      check("t6_idle", 32'(busy), 32'd0);
      tick();
      check("t6_no_req2", 32'(imem_req), 32'd0);
      check("t6_err_cleared", 32'(fetch_err), 32'd0);
`else
      start(32'h0040_0002);
      check("t6_forced_addr", imem_addr, 32'h0040_0000);
      check("t6_pc4", pc_plus4, 32'h0040_0004);
      serve(32'h0040_0000, 1, 32'h0000_000C, 32'h0040_0004);
      tick();
`endif
      tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
